// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared definitions for the display window scroller:
//                MODE input encodings, controller state type, index-width
//                and window-limit helpers, parameter sanity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // MODE input encodings; 2'b11 is decoded as manual.
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_EDIT   = 2'b10;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_EDIT   = 2'd2
    } state_t;

    // Index width for a count of n items; never narrower than 1 bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Highest slot index the window's digit 0 may sit on.
    function automatic int calc_max_pos(input int num_digits, input int win_digits);
        return num_digits - win_digits;
    endfunction

    // True when the parameter set describes a usable window geometry.
    function automatic bit params_ok(input int num_digits, input int win_digits,
                                     input int step, input int scroll_div);
        return (win_digits >= 1) && (win_digits <= num_digits) && (step >= 1) &&
               (((num_digits - win_digits) % step) == 0) && (scroll_div >= 1);
    endfunction

    // Controller state implied by the MODE input.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_AUTO: return ST_AUTO;
            MODE_EDIT: return ST_EDIT;
            default:   return ST_MANUAL;
        endcase
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/window_pos_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : window_pos_ctrl
//  Description : Mode FSM, window position register, auto-scroll divider
//                and edit blink phase for the display window scroller.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_tick            - 1 Hz single-cycle enable
//                i_mode            - requested mode (display_pkg encodings)
//                i_step_up/dn      - manual step pulses
//                i_edit_field      - lowest slot of the edited field
//                o_pos             - registered window position
//                o_blank_en        - blink phase active while staying in edit
//  Revision    : 1.0 - initial release
// ============================================================================
module window_pos_ctrl
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS = 14,
    parameter  int WIN_DIGITS = 4,
    parameter  int STEP       = 2,
    parameter  int SCROLL_DIV = 2,
    localparam int IDX_W      = calc_idx_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [1:0]       i_mode,
    input  logic             i_step_up,
    input  logic             i_step_dn,
    input  logic [IDX_W-1:0] i_edit_field,
    output logic [IDX_W-1:0] o_pos,
    output logic             o_blank_en
);

    localparam int MAX_POS = calc_max_pos(NUM_DIGITS, WIN_DIGITS);
    localparam int CNT_W   = calc_idx_w(SCROLL_DIV);

    localparam logic [IDX_W-1:0] c_max_pos  = IDX_W'(MAX_POS);
    localparam logic [IDX_W-1:0] c_step     = IDX_W'(STEP);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCROLL_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_entry;
    logic [IDX_W-1:0] r_pos;
    logic [IDX_W-1:0] w_pos_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_phase;
    logic             w_phase_nxt;
    logic [IDX_W-1:0] w_lock_pos;
    int               w_aligned;

    // Edit lock position: field rounded down to a STEP boundary, clamped to
    // the top window; an out-of-range field parks the window at the top.
    always_comb begin
        w_aligned  = (int'(i_edit_field) / STEP) * STEP;
        w_lock_pos = c_max_pos;
        if ((int'(i_edit_field) < NUM_DIGITS) && (w_aligned < MAX_POS)) begin
            w_lock_pos = IDX_W'(w_aligned);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MANUAL;
            r_pos   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // The cycle's work is done by the mode being entered/held, so entry
    // actions land on the same edge that registers the new state; a tick on
    // that edge is swallowed by the entry clear.
    always_comb begin
        w_state_nxt = mode_to_state(i_mode);
        w_entry     = (w_state_nxt != r_state);
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = 1'b0;

        case (w_state_nxt)
            ST_AUTO: begin
                if (w_entry) begin
                    w_cnt_nxt = '0;
                end else if (i_tick) begin
                    if (r_cnt == c_cnt_last) begin
                        w_cnt_nxt = '0;
                        w_pos_nxt = (r_pos >= c_max_pos) ? '0 : r_pos + c_step;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_EDIT: begin
                w_pos_nxt = w_lock_pos;
                if (w_entry) begin
                    w_phase_nxt = 1'b0;
                end else begin
                    w_phase_nxt = r_phase ^ i_tick;
                end
            end

            default: begin
                // Manual: saturating steps, simultaneous presses cancel.
                if (i_step_up && !i_step_dn) begin
                    w_pos_nxt = (r_pos >= c_max_pos - c_step) ? c_max_pos : r_pos + c_step;
                end else if (i_step_dn && !i_step_up) begin
                    w_pos_nxt = (r_pos < c_step) ? '0 : r_pos - c_step;
                end
            end
        endcase
    end

    assign o_pos = r_pos;
    // Gated with the incoming mode so blanking stops on the edge edit is left.
    assign o_blank_en = r_phase && (w_state_nxt == ST_EDIT);

endmodule : window_pos_ctrl
`default_nettype wire

// File: rtl/display_window_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : display_window_scroller
//  Description : Sliding WIN_DIGITS-wide window over a packed BCD digit bank
//                with manual, auto-scroll and edit (locked + blinking) modes.
//                All outputs registered one cycle after the window position.
//  Ports       : CLK, RESET        - clock, synchronous active-high reset
//                TICK_1HZ          - 1 Hz single-cycle enable
//                DIGITS_IN         - packed digits, slot i at [4i+3:4i]
//                MODE              - 00 manual, 01 auto, 10 edit, 11 manual
//                STEP_UP/STEP_DN   - manual step pulses
//                EDIT_FIELD        - lowest slot of the edited field
//                DIGITS_OUT        - window digit d = slot WIN_POS+d
//                BLANK_OUT         - per-digit blank request
//                WIN_POS           - slot index of window digit 0
//                AT_TOP            - window at highest position
//  Revision    : 1.0 - initial release
// ============================================================================
module display_window_scroller
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS = 14,
    parameter  int WIN_DIGITS = 4,
    parameter  int STEP       = 2,
    parameter  int SCROLL_DIV = 2,
    localparam int IDX_W      = calc_idx_w(NUM_DIGITS)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TICK_1HZ,
    input  logic [NUM_DIGITS*4-1:0] DIGITS_IN,
    input  logic [1:0]              MODE,
    input  logic                    STEP_UP,
    input  logic                    STEP_DN,
    input  logic [IDX_W-1:0]        EDIT_FIELD,
    output logic [WIN_DIGITS*4-1:0] DIGITS_OUT,
    output logic [WIN_DIGITS-1:0]   BLANK_OUT,
    output logic [IDX_W-1:0]        WIN_POS,
    output logic                    AT_TOP
);

    localparam int MAX_POS = calc_max_pos(NUM_DIGITS, WIN_DIGITS);
    // Slot arithmetic width with headroom for field + STEP.
    localparam int c_cw    = IDX_W + 2;
    // Bit-index width into DIGITS_IN.
    localparam int c_bw    = calc_idx_w(NUM_DIGITS * 4);

    localparam logic [IDX_W-1:0] c_max_pos = IDX_W'(MAX_POS);

    if (!params_ok(NUM_DIGITS, WIN_DIGITS, STEP, SCROLL_DIV)) begin : g_bad_params
        $error("display_window_scroller: invalid NUM_DIGITS/WIN_DIGITS/STEP/SCROLL_DIV");
    end

    logic [IDX_W-1:0]        w_pos;
    logic                    w_blank_en;
    logic                    w_field_valid;
    logic [WIN_DIGITS*4-1:0] w_window;
    logic [WIN_DIGITS-1:0]   w_mask;

    logic [WIN_DIGITS*4-1:0] r_digits;
    logic [WIN_DIGITS-1:0]   r_blank;
    logic [IDX_W-1:0]        r_win_pos;
    logic                    r_at_top;

    window_pos_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .WIN_DIGITS (WIN_DIGITS),
        .STEP       (STEP),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_pos_ctrl (
        .clk          (CLK),
        .rst          (RESET),
        .i_tick       (TICK_1HZ),
        .i_mode       (MODE),
        .i_step_up    (STEP_UP),
        .i_step_dn    (STEP_DN),
        .i_edit_field (EDIT_FIELD),
        .o_pos        (w_pos),
        .o_blank_en   (w_blank_en)
    );

    // A field index past the digit bank never blanks anything.
    assign w_field_valid = (int'(EDIT_FIELD) < NUM_DIGITS);

    // Per window digit: slot mux and edited-field membership test.
    for (genvar d = 0; d < WIN_DIGITS; d++) begin : g_digit
        logic [c_cw-1:0] w_slot;
        logic [c_bw-1:0] w_lsb;

        assign w_slot = c_cw'(w_pos) + c_cw'(d);
        assign w_lsb  = c_bw'({w_slot, 2'b00});

        assign w_window[d*4 +: 4] = DIGITS_IN[w_lsb +: 4];
        assign w_mask[d] = (w_slot >= c_cw'(EDIT_FIELD)) &&
                           (w_slot <  c_cw'(EDIT_FIELD) + c_cw'(STEP));
    end

    // Digits, position, top flag and blank mask share one register stage so
    // the scan driver always sees a coherent set.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_digits  <= '0;
            r_blank   <= '0;
            r_win_pos <= '0;
            r_at_top  <= 1'b0;
        end else begin
            r_digits  <= w_window;
            r_win_pos <= w_pos;
            r_at_top  <= (w_pos == c_max_pos);
            r_blank   <= (w_blank_en && w_field_valid) ? w_mask : '0;
        end
    end

    assign DIGITS_OUT = r_digits;
    assign BLANK_OUT  = r_blank;
    assign WIN_POS    = r_win_pos;
    assign AT_TOP     = r_at_top;

endmodule : display_window_scroller
`default_nettype wire

// File: tb/tb_display_window_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_window_scroller
//  Description : Directed self-checking bench for display_window_scroller
//                with default parameters (14 digits, window 4, step 2,
//                scroll divider 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_window_scroller;

    localparam int NUM_DIGITS = 14;
    localparam int WIN_DIGITS = 4;
    localparam int IDX_W      = 4;

    logic                    clk;
    logic                    rst;
    logic                    tick;
    logic [NUM_DIGITS*4-1:0] digits_in;
    logic [1:0]              mode;
    logic                    step_up;
    logic                    step_dn;
    logic [IDX_W-1:0]        edit_field;
    logic [WIN_DIGITS*4-1:0] digits_out;
    logic [WIN_DIGITS-1:0]   blank_out;
    logic [IDX_W-1:0]        win_pos;
    logic                    at_top;

    int n_checks = 0;
    int n_fail   = 0;

    display_window_scroller #(
        .NUM_DIGITS (14),
        .WIN_DIGITS (4),
        .STEP       (2),
        .SCROLL_DIV (2)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .TICK_1HZ   (tick),
        .DIGITS_IN  (digits_in),
        .MODE       (mode),
        .STEP_UP    (step_up),
        .STEP_DN    (step_dn),
        .EDIT_FIELD (edit_field),
        .DIGITS_OUT (digits_out),
        .BLANK_OUT  (blank_out),
        .WIN_POS    (win_pos),
        .AT_TOP     (at_top)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse on the edge, then one more edge for the output register.
    task automatic pulse_up();
        step_up = 1'b1; cycle(); step_up = 1'b0; cycle();
    endtask

    task automatic pulse_dn();
        step_dn = 1'b1; cycle(); step_dn = 1'b0; cycle();
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cycle(); tick = 1'b0; cycle();
    endtask

    int exp_up [6] = '{2, 4, 6, 8, 10, 10};

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        mode       = 2'b00;
        step_up    = 1'b0;
        step_dn    = 1'b0;
        edit_field = '0;
        digits_in  = 56'hDCBA9876543210;

        // Reset and manual limits
        cycle(); cycle();
        chk("rst_digits", 64'(digits_out), 64'h0);
        chk("rst_blank",  64'(blank_out),  64'h0);
        chk("rst_pos",    64'(win_pos),    64'h0);
        chk("rst_top",    64'(at_top),     64'h0);

        rst = 1'b0;
        cycle();
        chk("rel_digits", 64'(digits_out), 64'h3210);
        chk("rel_pos",    64'(win_pos),    64'h0);

        pulse_dn();
        chk("dn_sat0", 64'(win_pos), 64'h0);

        for (int i = 0; i < 6; i++) begin
            pulse_up();
            chk($sformatf("up_%0d", i), 64'(win_pos), 64'(exp_up[i]));
        end
        chk("top_flag",   64'(at_top),     64'h1);
        chk("top_digits", 64'(digits_out), 64'hDCBA);

        // Simultaneous buttons at position 4
        pulse_dn(); pulse_dn(); pulse_dn();
        chk("dn_to4", 64'(win_pos), 64'h4);
        step_up = 1'b1; step_dn = 1'b1; cycle();
        step_up = 1'b0; step_dn = 1'b0; cycle();
        chk("both_pos",    64'(win_pos),    64'h4);
        chk("both_digits", 64'(digits_out), 64'h7654);
        chk("both_top",    64'(at_top),     64'h0);

        // Auto wrap from position 8, buttons ignored
        pulse_up(); pulse_up();
        chk("pre_auto", 64'(win_pos), 64'h8);
        mode = 2'b01; cycle();
        pulse_tick();
        chk("auto_t1", 64'(win_pos), 64'h8);
        pulse_up();
        chk("auto_btn", 64'(win_pos), 64'h8);
        pulse_tick();
        chk("auto_t2", 64'(win_pos), 64'hA);
        chk("auto_t2_top", 64'(at_top), 64'h1);
        pulse_tick();
        chk("auto_t3", 64'(win_pos), 64'hA);
        pulse_tick();
        chk("auto_wrap", 64'(win_pos), 64'h0);
        chk("auto_wrap_digits", 64'(digits_out), 64'h3210);

        // Edit lock and blink, field 4
        mode = 2'b10; edit_field = 4'd4; cycle(); cycle();
        chk("edit4_pos",   64'(win_pos),   64'h4);
        chk("edit4_blank0", 64'(blank_out), 64'h0);
        cycle(); cycle();
        chk("edit4_blank_hold", 64'(blank_out), 64'h0);
        pulse_tick();
        chk("edit4_blank1", 64'(blank_out),  64'h3);
        chk("edit4_digits", 64'(digits_out), 64'h7654);
        pulse_tick();
        chk("edit4_blank2", 64'(blank_out), 64'h0);

        // Field 12 clamps to the top window
        edit_field = 4'd12; cycle(); cycle();
        chk("edit12_pos", 64'(win_pos), 64'hA);
        pulse_tick();
        chk("edit12_blank1", 64'(blank_out), 64'hC);
        pulse_tick();
        chk("edit12_blank2", 64'(blank_out), 64'h0);

        // Out-of-range field never blanks
        edit_field = 4'd15; cycle(); cycle();
        chk("edit15_pos", 64'(win_pos), 64'hA);
        pulse_tick();
        chk("edit15_blank1", 64'(blank_out), 64'h0);
        pulse_tick();
        chk("edit15_blank2", 64'(blank_out), 64'h0);
        pulse_tick();
        chk("edit15_blank3", 64'(blank_out), 64'h0);

        // Phase is now 1: a valid field shows blanking, then leave edit
        edit_field = 4'd12; cycle();
        chk("pre_exit_blank", 64'(blank_out), 64'hC);
        mode = 2'b00; cycle();
        chk("exit_blank", 64'(blank_out), 64'h0);
        chk("exit_pos",   64'(win_pos),   64'hA);

        // Reset in the middle of auto with counter 1 at position 6
        pulse_dn(); pulse_dn();
        chk("pre_auto2", 64'(win_pos), 64'h6);
        mode = 2'b01; cycle();
        pulse_tick();
        chk("auto2_t1", 64'(win_pos), 64'h6);
        rst = 1'b1; cycle();
        chk("midrst_digits", 64'(digits_out), 64'h0);
        chk("midrst_pos",    64'(win_pos),    64'h0);
        chk("midrst_top",    64'(at_top),     64'h0);
        chk("midrst_blank",  64'(blank_out),  64'h0);
        rst = 1'b0; cycle();
        chk("postrst_digits", 64'(digits_out), 64'h3210);
        pulse_tick();
        chk("postrst_t1", 64'(win_pos), 64'h0);
        pulse_tick();
        chk("postrst_t2", 64'(win_pos), 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_display_window_scroller
`default_nettype wire
